// File: rtl/calc_operand_entry_if.sv
// Operand bus from the entry front end to the ALU / display datapath.
`timescale 1ns/1ps
interface calc_operand_entry_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [1:0] stage;
    logic       operands_valid;
    logic       start;

    modport master (
        output a, b, op, stage, operands_valid, start
    );

    modport slave (
        input a, b, op, stage, operands_valid, start
    );
endinterface

// File: rtl/calc_operand_entry.sv
// Stepped operand entry: synchronizes the switches, debounces ENTER/CLEAR,
// and captures A, B and the opcode in sequence onto the operand bus.
// Optional debounce counters: define CALC_OPERAND_ENTRY_DEBOUNCE_EN.
`timescale 1ns/1ps
module calc_operand_entry #(
    parameter int unsigned DB_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            sw_data,
    input  logic                  key_enter_n,
    input  logic                  key_clear_n,
    calc_operand_entry_if.master  bus
);

    localparam int unsigned SW_W      = 4;
    localparam int unsigned OP_W      = 2;
    localparam int unsigned NKEY      = 2;
    localparam int unsigned KEY_ENTER = 0;
    localparam int unsigned KEY_CLEAR = 1;

    typedef enum logic [1:0] {
        ENTER_A  = 2'd0,
        ENTER_B  = 2'd1,
        ENTER_OP = 2'd2,
        DONE     = 2'd3
    } state_t;

    // Elaboration guard on the debounce length.
    if (DB_CYCLES < 2) begin : g_db_check
        $error("DB_CYCLES must be at least 2");
    end

    logic [SW_W-1:0] sw_s1;
    logic [SW_W-1:0] sw_s2;
    logic [NKEY-1:0] key_raw;
    logic [NKEY-1:0] key_s1;
    logic [NKEY-1:0] key_s2;
    logic [NKEY-1:0] key_db;
    logic [NKEY-1:0] key_db_d;
    logic [NKEY-1:0] press;

    state_t          state;
    state_t          state_nxt;
    logic [SW_W-1:0] a_q;
    logic [SW_W-1:0] b_q;
    logic [OP_W-1:0] op_q;
    logic            valid_q;
    logic            start_q;
    logic [SW_W-1:0] a_nxt;
    logic [SW_W-1:0] b_nxt;
    logic [OP_W-1:0] op_nxt;
    logic            valid_nxt;
    logic            start_nxt;
    logic            enter_ev;
    logic            clear_ev;

    assign key_raw = {key_clear_n, key_enter_n};

    // Two-flop synchronizers; keys reset to the released level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            key_s1 <= '1;
            key_s2 <= '1;
        end else begin
            sw_s1  <= sw_data;
            sw_s2  <= sw_s1;
            key_s1 <= key_raw;
            key_s2 <= key_s1;
        end
    end

`ifdef CALC_OPERAND_ENTRY_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DB_CYCLES);

    logic [CNT_W-1:0] db_cnt [NKEY];
    logic [NKEY-1:0]  db_q;

    // Per-key debounce: flip only after DB_CYCLES consecutive differing cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q <= '1;
            for (int k = 0; k < NKEY; k++) begin
                db_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                if (key_s2[k] != db_q[k]) begin
                    if (db_cnt[k] == CNT_W'(DB_CYCLES - 1)) begin
                        db_q[k]   <= key_s2[k];
                        db_cnt[k] <= '0;
                    end else begin
                        db_cnt[k] <= db_cnt[k] + CNT_W'(1);
                    end
                end else begin
                    db_cnt[k] <= '0;
                end
            end
        end
    end

    assign key_db = db_q;
`else
    assign key_db = key_s2;
`endif

    // Registered one-cycle press event on each debounced falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_d <= '1;
            press    <= '0;
        end else begin
            key_db_d <= key_db;
            press    <= key_db_d & ~key_db;
        end
    end

    assign enter_ev = press[KEY_ENTER];
    assign clear_ev = press[KEY_CLEAR];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ENTER_A;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; clear takes priority over enter.
    always_comb begin
        state_nxt = state;
        if (clear_ev) begin
            state_nxt = ENTER_A;
        end else if (enter_ev) begin
            case (state)
                ENTER_A:  state_nxt = ENTER_B;
                ENTER_B:  state_nxt = ENTER_OP;
                ENTER_OP: state_nxt = DONE;
                DONE:     state_nxt = ENTER_A;
                default:  state_nxt = ENTER_A;
            endcase
        end
    end

    // Next values of the captured operands and status flags.
    always_comb begin
        a_nxt     = a_q;
        b_nxt     = b_q;
        op_nxt    = op_q;
        start_nxt = 1'b0;
        valid_nxt = (state_nxt == DONE);
        if (clear_ev) begin
            a_nxt  = '0;
            b_nxt  = '0;
            op_nxt = '0;
        end else if (enter_ev) begin
            case (state)
                ENTER_A:  a_nxt = sw_s2;
                ENTER_B:  b_nxt = sw_s2;
                ENTER_OP: begin
                    op_nxt    = sw_s2[OP_W-1:0];
                    start_nxt = 1'b1;
                end
                default:  ;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
        end else begin
            a_q     <= a_nxt;
            b_q     <= b_nxt;
            op_q    <= op_nxt;
            valid_q <= valid_nxt;
            start_q <= start_nxt;
        end
    end

    assign bus.a              = a_q;
    assign bus.b              = b_q;
    assign bus.op             = op_q;
    assign bus.stage          = state;
    assign bus.operands_valid = valid_q;
    assign bus.start          = start_q;

endmodule

// File: doc/calc_operand_entry.md
# calc_operand_entry

Sequential operand-entry front end for the 4-bit switch calculator. It debounces the board's ENTER and CLEAR pushbuttons and walks a state machine that captures operand A, operand B and the opcode one at a time from the same four switches. It then presents them, held stable and qualified by a valid flag, to the ALU and display datapath. This replaces the direct switch-to-operand wiring with a stepped entry sequence, so the entered operands are the block's outputs rather than its inputs.

## Interface
- DB_CYCLES, 500000, consecutive cycles a synchronized key level must differ from the debounced level before the debounced level flips (10 ms at 50 MHz); legal range ≥ 2
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sw_data  in  4  raw switch value captured on each ENTER press
- key_enter_n  in  1  raw ENTER pushbutton, active-low, asynchronous to clk
- key_clear_n  in  1  raw CLEAR pushbutton, active-low, asynchronous to clk
- a  out  4  captured operand A
- b  out  4  captured operand B
- op  out  2  captured opcode (sw_data[1:0] at capture)
- stage  out  2  current state encoding, for a stage indicator: 0 ENTER_A, 1 ENTER_B, 2 ENTER_OP, 3 DONE
- operands_valid  out  1  high while in DONE
- start  out  1  one-cycle pulse on entry to DONE

## Operation
- Synchronization:
  - sw_data passes through a 2-flop synchronizer; the synchronized value is what gets captured.
  - Each key passes through a 2-flop synchronizer, reset value 1 (released).
- Debounce, per key:
  - The debounced level resets to 1; the counter resets to 0.
  - Each cycle the synchronized level differs from the debounced level, the counter increments.
  - When the counter reaches DB_CYCLES-1 and the levels still differ, the debounced level flips and the counter clears.
  - Any cycle the levels agree, the counter clears.
- Press event: a one-cycle pulse when the debounced level goes 1→0. The release (0→1) produces no event.
- State machine, with reset state ENTER_A:
  - ENTER_A + enter press → a ← sw_sync, go to ENTER_B.
  - ENTER_B + enter press → b ← sw_sync, go to ENTER_OP.
  - ENTER_OP + enter press → op ← sw_sync[1:0], go to DONE, start pulses.
  - DONE + enter press → go to ENTER_A; a, b and op are retained until overwritten; operands_valid drops.
  - Clear press in any state → go to ENTER_A; a, b and op are cleared to 0.
- Clear press and enter press in the same cycle: clear wins and the enter press is discarded.
- Presses never queue: each press affects exactly one transition.
- Reset mid-sequence: all registers return to their reset values immediately, whatever the state.

## Timing
- Reset values: a=0, b=0, op=0, stage=0, operands_valid=0, start=0.
- Key latency: the press pulse asserts in cycle N = 2 + DB_CYCLES cycles after the first clk edge that samples the raw key held low with no bounce. The register/state update is visible in cycle N+1.
- start is high only in cycle N+1 of the third ENTER press; operands_valid rises in the same cycle.
- stage, a, b, op and operands_valid are all registered outputs, with no combinational path from the inputs.
- Bounce shorter than DB_CYCLES cycles produces no event. A key held low indefinitely produces exactly one event.

## Configuration
- CALC_OPERAND_ENTRY_DEBOUNCE_EN
  - Defined: the debounce counters are built as described above.
  - Undefined: the debounced level equals the synchronized level directly and no counters are instantiated. Press pulse latency becomes 3 cycles from the raw key falling. Use this for fast simulation or for externally debounced keys.

## Test plan
- Debounce is enabled with DB_CYCLES=4 unless stated otherwise.
- Reset, then three clean ENTER presses with sw_data=5, 9, 2 → a=5, b=9, op=2, stage=3, operands_valid=1, start high exactly one cycle.
- ENTER key bounces low/high for 3 cycles, 4 times, then stays low → exactly one press; state ENTER_A→ENTER_B; a captured from sw_data at debounce completion.
- In ENTER_OP, assert CLEAR and ENTER so that both debounce in the same cycle → stage=0; a=b=op=0; no start.
- From DONE, press ENTER → stage=0, operands_valid=0, a/b/op unchanged. Enter 7, 3, 1 → a=7, b=3, op=1.
- Pulse rst_n low for 1 ns, asynchronously, mid-debounce while in ENTER_B → all outputs 0 immediately. The partially counted press does not register after release.
- With CALC_OPERAND_ENTRY_DEBOUNCE_EN undefined, ENTER falls → press pulse 3 cycles later and stage advances in the following cycle.
